// File: rtl/n64_joybus_master_if.sv
// Request/reply bus of the Joybus master: command trigger side plus reply/status side.
// The requester drives the master modport; the Joybus engine sits on the slave modport.
interface n64_joybus_master_if #(
   parameter int RESP_BITS = 32
);
   logic                 start;
   logic                 auto_poll;
   logic [7:0]           cmd;
   logic                 busy;
   logic [RESP_BITS-1:0] resp;
   logic                 resp_valid;
   logic                 timeout_err;
   logic                 frame_err;
   logic [3:0]           state;

   // start is a 1-cycle request pulse, honoured only while busy is low and dropped otherwise;
   // resp is qualified by the 1-cycle resp_valid pulse and holds until the next good reply.
   modport master (
      output start, auto_poll, cmd,
      input  busy, resp, resp_valid, timeout_err, frame_err, state
   );

   modport slave (
      input  start, auto_poll, cmd,
      output busy, resp, resp_valid, timeout_err, frame_err, state
   );
endinterface

// File: rtl/n64_joybus_master.sv
// Joybus master: sends an 8-bit command on the open-drain pad, then captures the controller reply
// with edge-aligned sampling; supports one-shot and periodic polling with timeout/framing checks.
module n64_joybus_master #(
   parameter int TICKS_PER_US   = 25,
   parameter int RESP_BITS      = 32,
   parameter int POLL_PERIOD_US = 1000,
   parameter int TIMEOUT_US     = 64,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                    PCLK,
   input  logic                    RST,
   input  logic                    data_in,
   output logic                    data_oe,
   n64_joybus_master_if.slave      bus
);

   localparam int US1        = TICKS_PER_US;
   localparam int US2        = 2 * TICKS_PER_US;
   localparam int US3        = 3 * TICKS_PER_US;
   localparam int US4        = 4 * TICKS_PER_US;
   localparam int TO_TICKS   = TIMEOUT_US * TICKS_PER_US;
   localparam int TICK_MAX   = (TO_TICKS > US4) ? TO_TICKS : US4;
   localparam int TW         = $clog2(TICK_MAX + 1);
   localparam int POLL_TICKS = POLL_PERIOD_US * TICKS_PER_US;
   localparam int PW         = $clog2(POLL_TICKS + 1);
   localparam int BW         = $clog2(RESP_BITS + 2);

   typedef enum logic [3:0] {
      S_IDLE, S_TX_LOW, S_TX_HIGH, S_TX_STOP,
      S_RX_EDGE, S_RX_SAMPLE, S_RX_HIGH, S_DONE
   } state_t;

   state_t               state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 line;
   logic                 line_prev;
   logic                 fall;
   logic [TW-1:0]        tick;
   logic [PW-1:0]        poll_cnt;
   logic                 poll_expired;
   logic                 accept;
   logic [7:0]           tx_sh;
   logic [2:0]           tx_cnt;
   logic [BW-1:0]        rx_cnt;
   logic [RESP_BITS-1:0] shreg;
   logic [RESP_BITS-1:0] resp_q;
   logic                 resp_valid_q;
   logic                 timeout_err_q;
   logic                 frame_err_q;
   logic [TW-1:0]        lo_end;
   logic [TW-1:0]        hi_end;

   assign line         = sync_q[SYNC_STAGES-1];
   assign fall         = line_prev & ~line;
   assign poll_expired = (poll_cnt == PW'(POLL_TICKS - 1));
   assign accept       = (state == S_IDLE) && (bus.start || (bus.auto_poll && poll_expired));
   assign lo_end       = tx_sh[7] ? TW'(US1 - 1) : TW'(US3 - 1);
   assign hi_end       = tx_sh[7] ? TW'(US3 - 1) : TW'(US1 - 1);

   assign bus.busy        = (state != S_IDLE);
   assign bus.state       = state;
   assign bus.resp        = resp_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.frame_err   = frame_err_q;

   always_ff @(posedge PCLK) begin
      if (RST) begin
         // Synchroniser resets to the idle (pulled-up) level so no false edge appears.
         sync_q        <= '1;
         line_prev     <= 1'b1;
         state         <= S_IDLE;
         tick          <= '0;
         poll_cnt      <= '0;
         tx_sh         <= '0;
         tx_cnt        <= '0;
         rx_cnt        <= '0;
         shreg         <= '0;
         resp_q        <= '0;
         data_oe       <= 1'b0;
         resp_valid_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         sync_q        <= {sync_q[SYNC_STAGES-2:0], data_in};
         line_prev     <= line;
         resp_valid_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         frame_err_q   <= 1'b0;

         if (accept)
            poll_cnt <= '0;
         else if (!poll_expired)
            poll_cnt <= poll_cnt + PW'(1);

         case (state)
            S_IDLE: begin
               data_oe <= 1'b0;
               if (accept) begin
                  tx_sh   <= bus.cmd;
                  tx_cnt  <= '0;
                  tick    <= '0;
                  rx_cnt  <= '0;
                  shreg   <= '0;
                  data_oe <= 1'b1;
                  state   <= S_TX_LOW;
               end
            end
            S_TX_LOW: begin
               if (tick == lo_end) begin
                  tick    <= '0;
                  data_oe <= 1'b0;
                  state   <= S_TX_HIGH;
               end else begin
                  tick <= tick + TW'(1);
               end
            end
            S_TX_HIGH: begin
               if (tick == hi_end) begin
                  tick    <= '0;
                  data_oe <= 1'b1;
                  if (tx_cnt == 3'd7) begin
                     state <= S_TX_STOP;
                  end else begin
                     tx_cnt <= tx_cnt + 3'd1;
                     tx_sh  <= {tx_sh[6:0], 1'b0};
                     state  <= S_TX_LOW;
                  end
               end else begin
                  tick <= tick + TW'(1);
               end
            end
            S_TX_STOP: begin
               if (tick == TW'(US1 - 1)) begin
                  tick    <= '0;
                  data_oe <= 1'b0;
                  state   <= S_RX_EDGE;
               end else begin
                  tick <= tick + TW'(1);
               end
            end
            S_RX_EDGE: begin
               // The edge cycle itself counts as tick 0, so the counter resumes at 1.
               if (fall) begin
                  tick  <= TW'(1);
                  state <= S_RX_SAMPLE;
               end else if (tick == TW'(TO_TICKS - 1)) begin
                  timeout_err_q <= 1'b1;
                  state         <= S_IDLE;
               end else begin
                  tick <= tick + TW'(1);
               end
            end
            S_RX_SAMPLE: begin
               tick <= tick + TW'(1);
               if (tick == TW'(US2)) begin
                  rx_cnt <= rx_cnt + BW'(1);
                  state  <= S_RX_HIGH;
                  if (rx_cnt < BW'(RESP_BITS)) begin
                     shreg <= (shreg << 1) | RESP_BITS'(line);
                  end else if (line) begin
                     frame_err_q <= 1'b1;
                     state       <= S_IDLE;
                  end
               end
            end
            S_RX_HIGH: begin
               if (line) begin
                  tick  <= '0;
                  state <= (rx_cnt == BW'(RESP_BITS + 1)) ? S_DONE : S_RX_EDGE;
               end else if (tick == TW'(US4)) begin
                  frame_err_q <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  tick <= tick + TW'(1);
               end
            end
            S_DONE: begin
               resp_q       <= shreg;
               resp_valid_q <= 1'b1;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
